// File: rtl/fm_chunk_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fm_chunk_rx
// Purpose  : Receives multi-byte chunks into a small FIFO and serializes them
//            MSB byte first onto a byte stream with valid/ready handshake.
//            Tracks byte position inside a frame-memory buffer (out_last) and
//            the buffer parity (out_buf_idx).
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            in_chunk_valid/_data/_ready - chunk input handshake
//            out_valid/_data/_ready      - byte output handshake
//            out_last           - current byte is last of a buffer
//            out_buf_idx        - buffer parity of current byte
//            overflow           - sticky chunk-drop flag
// Config   : FM_CHUNK_RX_OVF_EN - when defined, builds the sticky overflow
//            detector; otherwise overflow is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module fm_chunk_rx #(
    parameter int CHUNK_SIZE  = 2,
    parameter int DATA_BITS   = 8,
    parameter int BUFFER_SIZE = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_chunk_valid,
    input  logic [CHUNK_SIZE*DATA_BITS-1:0] in_chunk_data,
    output logic                            in_chunk_ready,
    output logic                            out_valid,
    output logic [DATA_BITS-1:0]            out_data,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            out_buf_idx,
    output logic                            overflow
);

    localparam int CW    = CHUNK_SIZE * DATA_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int IDX_W = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam int BC_W  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHUNK_SIZE - 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BUFFER_SIZE - 1);
    localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Chunk FIFO
    // ------------------------------------------------------------------
    logic [CW-1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;

    logic push;
    logic pop;
    logic fifo_nempty;

    // Ready depends on registered occupancy only, so a pop in the same
    // cycle never opens an extra slot combinationally.
    assign in_chunk_ready = (occ_q != FULL_OCC);
    assign push           = in_chunk_valid && in_chunk_ready;
    assign fifo_nempty    = (occ_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_chunk_data;
        end
    end

    // Pointers are exactly PTR_W bits wide; FIFO_DEPTH is a power of two so
    // natural binary overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    shreg_q;
    logic [CW-1:0]    shreg_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             out_hs;

    assign out_valid = (state_q == ST_SHIFT);
    assign out_hs    = out_valid && out_ready;
    // The shift register is left-shifted on each accepted byte, so the
    // current byte always sits in the top DATA_BITS.
    assign out_data  = out_valid ? shreg_q[CW-1 -: DATA_BITS] : '0;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_mem_q[rd_ptr_q];
                    idx_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (out_hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // Back-to-back reload keeps the stream gap-free.
                        if (fifo_nempty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_mem_q[rd_ptr_q];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shreg_d = shreg_q << DATA_BITS;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Buffer byte counter and parity
    // ------------------------------------------------------------------
    logic [BC_W-1:0] bcnt_q;
    logic [BC_W-1:0] bcnt_d;
    logic            bidx_q;
    logic            bidx_d;

    assign out_last    = (bcnt_q == LAST_BYTE);
    assign out_buf_idx = bidx_q;

    always_comb begin
        bcnt_d = bcnt_q;
        bidx_d = bidx_q;
        if (out_hs) begin
            if (out_last) begin
                bcnt_d = '0;
                bidx_d = ~bidx_q;
            end else begin
                bcnt_d = bcnt_q + BC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            bidx_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            bidx_q <= bidx_d;
        end
    end

    // ------------------------------------------------------------------
    // Overflow detection (optional)
    // ------------------------------------------------------------------
`ifdef FM_CHUNK_RX_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_chunk_valid && !in_chunk_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fm_chunk_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fm_chunk_rx
// Purpose  : Self-checking bench for fm_chunk_rx. Inputs change 1 ns after
//            the rising edge; outputs are sampled on the falling edge. A
//            reference model expands every accepted chunk into expected
//            bytes (with buffer position and parity) and a monitor pops and
//            compares them on each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fm_chunk_rx;

    localparam int CHUNK_SIZE  = 2;
    localparam int DATA_BITS   = 8;
    localparam int BUFFER_SIZE = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int CW          = CHUNK_SIZE * DATA_BITS;

`ifdef FM_CHUNK_RX_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_chunk_valid;
    logic [CW-1:0]        in_chunk_data;
    logic                 in_chunk_ready;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_ready;
    logic                 out_last;
    logic                 out_buf_idx;
    logic                 overflow;

    always #5 clk = ~clk;

    fm_chunk_rx #(
        .CHUNK_SIZE  (CHUNK_SIZE),
        .DATA_BITS   (DATA_BITS),
        .BUFFER_SIZE (BUFFER_SIZE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_chunk_valid (in_chunk_valid),
        .in_chunk_data  (in_chunk_data),
        .in_chunk_ready (in_chunk_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .out_buf_idx    (out_buf_idx),
        .overflow       (overflow)
    );

    typedef struct packed {
        logic [DATA_BITS-1:0] d;
        logic                 last;
        logic                 bidx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   hs_first_cyc = 0;
    int   hs_last_cyc = 0;
    int   m_cnt = 0;
    logic m_buf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: every accepted chunk becomes CHUNK_SIZE bytes, MSB
    // first; each byte's buffer position follows from how many bytes have
    // been accepted before it since reset.
    function automatic void model_push(input logic [CW-1:0] d);
        exp_t e;
        for (int k = 0; k < CHUNK_SIZE; k++) begin
            e.d    = DATA_BITS'(d >> ((CHUNK_SIZE - 1 - k) * DATA_BITS));
            e.last = (m_cnt == BUFFER_SIZE - 1);
            e.bidx = m_buf;
            exp_q.push_back(e);
            m_cnt = (m_cnt + 1) % BUFFER_SIZE;
            if (e.last) m_buf = ~m_buf;
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic                 stall_q = 1'b0;
    logic [DATA_BITS-1:0] stall_data = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 32'(out_valid), 32'(1));
                check("hold_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (hs_count == 1) hs_first_cyc = cyc;
                hs_last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected actual=%0h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte{data,last,bidx}", 32'({out_data, out_last, out_buf_idx}),
                          32'({e.d, e.last, e.bidx}));
                end
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] d, output bit acc);
        in_chunk_valid = 1'b1;
        in_chunk_data  = d;
        acc = in_chunk_ready;
        if (acc) model_push(d);
        tick();
        in_chunk_valid = 1'b0;
    endtask

    task automatic send_chunk(input logic [CW-1:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            offer(d, acc);
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit   acc;
        int   nacc;
        int   n;
        logic [CW-1:0] d;

        rst_n          = 1'b0;
        in_chunk_valid = 1'b0;
        in_chunk_data  = '0;
        out_ready      = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_out_buf_idx", 32'(out_buf_idx), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_in_ready", 32'(in_chunk_ready), 32'(1));

        // Eight back-to-back chunks fill exactly two buffers with no gaps
        out_ready = 1'b1;
        hs_count  = 0;
        for (int i = 0; i < 8; i++) begin
            send_chunk(CW'(16'h1100 + 16'h0202 * i + 16'h0001));
        end
        drain();
        check("b2b_byte_count", 32'(hs_count), 32'(16));
        check("b2b_no_gap", 32'(hs_last_cyc - hs_first_cyc), 32'(15));
        check("b2b_buf_idx_end", 32'(out_buf_idx), 32'(0));

        // Single chunk latency and byte order
        repeat (2) tick();
        offer(CW'(16'hA55A), acc);
        check("single_accept", 32'(acc), 32'(1));
        check("single_e0_valid", 32'(out_valid), 32'(0));
        tick();
        check("single_e1_valid", 32'(out_valid), 32'(1));
        check("single_e1_data", 32'(out_data), 32'(8'hA5));
        tick();
        check("single_e2_valid", 32'(out_valid), 32'(1));
        check("single_e2_data", 32'(out_data), 32'(8'h5A));
        tick();
        check("single_e3_valid", 32'(out_valid), 32'(0));

        // Back-pressure: serializer holds one chunk, FIFO takes four more
        out_ready = 1'b0;
        send_chunk(CW'(16'hC3D4));
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_preload_valid", 32'(out_valid), 32'(1));
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            offer(CW'(16'h2000 + i), acc);
            if (acc) nacc++;
            if (i == 3) check("bp_ready_after_4th", 32'(in_chunk_ready), 32'(0));
            if (i == 4) check("bp_overflow_5th", 32'(overflow), 32'(OVF_EXP));
        end
        check("bp_accept_count", 32'(nacc), 32'(4));
        repeat (4) tick();
        check("bp_stall_data", 32'(out_data), 32'(8'hC3));
        check("bp_overflow_sticky", 32'(overflow), 32'(OVF_EXP));
        drain();

        // Random traffic with 50% out_ready
        nacc = 0;
        n = 0;
        while (nacc < 100 && n < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) begin
                d = CW'($urandom());
                offer(d, acc);
                if (acc) nacc++;
            end else begin
                tick();
            end
            n++;
        end
        check("rand_accepts", 32'(nacc), 32'(100));
        drain();

        // Reset mid-frame
        out_ready = 1'b1;
        hs_count  = 0;
        for (int i = 0; i < 3; i++) begin
            send_chunk(CW'(16'h7700 + i));
        end
        n = 0;
        while (hs_count < 3 && n < 50) begin
            tick();
            n++;
        end
        check("mid_hs_reached", 32'(hs_count >= 3), 32'(1));
        rst_n = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        m_buf = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_data", 32'(out_data), 32'(0));
        check("mid_rst_overflow", 32'(overflow), 32'(0));
        check("mid_rst_buf_idx", 32'(out_buf_idx), 32'(0));
        check("mid_rst_last", 32'(out_last), 32'(0));
        check("mid_rst_ready", 32'(in_chunk_ready), 32'(1));
        repeat (3) tick();
        check("mid_rst_discard", 32'(out_valid), 32'(0));
        for (int i = 0; i < 4; i++) begin
            send_chunk(CW'(16'hE000 + 16'h0111 * i));
        end
        drain();
        check("mid_rst_buf_idx_after", 32'(out_buf_idx), 32'(1));

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fm_chunk_rx.md
FM_CHUNK_RX -- requirements
Module: fm_chunk_rx

Interface
REQ-001 SHALL have parameter CHUNK_SIZE, default 2, bytes per input chunk.
REQ-002 SHALL have parameter DATA_BITS, default 8, width of one output byte.
REQ-003 SHALL have parameter BUFFER_SIZE, default 64, bytes per frame-memory buffer; must be a multiple of CHUNK_SIZE.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, chunk FIFO entries; must be a power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port in_chunk_valid, input, 1, chunk present on in_chunk_data.
REQ-008 SHALL have port in_chunk_data, input, CHUNK_SIZE*DATA_BITS, chunk; most-significant byte is the earliest byte.
REQ-009 SHALL have port in_chunk_ready, output, 1, FIFO not full.
REQ-010 SHALL have port out_valid, output, 1, byte present on out_data.
REQ-011 SHALL have port out_data, output, DATA_BITS, serialized byte.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts byte.
REQ-013 SHALL have port out_last, output, 1, current byte is the last of a buffer.
REQ-014 SHALL have port out_buf_idx, output, 1, buffer parity of the current byte.
REQ-015 SHALL have port overflow, output, 1, sticky chunk-drop flag (see Configuration).

Function
REQ-016 SHALL accept a chunk into the FIFO on any rising edge where in_chunk_valid and in_chunk_ready are both 1.
REQ-017 SHALL drive in_chunk_ready = (FIFO occupancy < FIFO_DEPTH), computed from registered occupancy only; a pop in the same cycle does not raise ready.
REQ-018 SHALL run a serializer FSM with states IDLE and SHIFT.
REQ-019 IDLE with FIFO non-empty: pop the head chunk into the shift register, set byte index 0, go to SHIFT; IDLE with FIFO empty: stay, out_valid = 0.
REQ-020 SHIFT: out_valid = 1 and out_data = chunk byte at the current index, MSB byte first; advance the index only on out_valid && out_ready.
REQ-021 On the handshake of byte CHUNK_SIZE-1: if FIFO non-empty, pop the next chunk on the same edge and stay in SHIFT with no bubble; otherwise go to IDLE.
REQ-022 Latency: a chunk accepted at edge E into an empty FIFO with the FSM in IDLE SHALL show its first byte with out_valid = 1 after edge E+1.
REQ-023 out_data and out_valid SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-024 A byte counter 0..BUFFER_SIZE-1 SHALL increment per byte handshake and wrap to 0 after BUFFER_SIZE-1; out_last = 1 while the counter equals BUFFER_SIZE-1.
REQ-025 out_buf_idx SHALL toggle on the handshake of the byte with out_last = 1.
REQ-026 Push and pop on the same edge SHALL leave occupancy unchanged; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 With rst_n = 0 at an edge: FIFO emptied, FSM to IDLE, byte index and byte counter to 0, out_buf_idx = 0, overflow = 0, out_valid = 0, out_data = 0, out_last = 0, in_chunk_ready = 1 after that edge.
REQ-028 Reset mid-frame SHALL discard all buffered and partially serialized data; the first byte after reset is counter 0.

Configuration
REQ-029 Macro FM_CHUNK_RX_OVF_EN defined: in_chunk_valid = 1 while in_chunk_ready = 0 drops the chunk and sets overflow to 1 until reset.
REQ-030 Macro FM_CHUNK_RX_OVF_EN undefined: overflow is tied to 0 and no detection logic is built; dropping behaviour is unchanged.

Verification
REQ-031 Single chunk 0xA55A into an empty block, out_ready = 1 -> 0xA5 after E+1, then 0x5A, then out_valid = 0.
REQ-032 BUFFER_SIZE = 8, 8 back-to-back chunks, out_ready = 1 -> 16 bytes with no gaps; out_last on bytes 7 and 15; out_buf_idx 0 then 1, then 0 after byte 15.
REQ-033 out_ready = 0 for 10 cycles with 6 chunks offered -> in_chunk_ready = 0 after the 4th accept; with FM_CHUNK_RX_OVF_EN, overflow = 1 on the 5th valid; without it, overflow stays 0.
REQ-034 Random out_ready at 50% over 100 chunks -> byte order equals chunk MSB-first order; no byte duplicated or lost.
REQ-035 rst_n = 0 for one edge after byte 3 of a buffer -> out_valid = 0 and overflow = 0; the next accepted chunk yields counter 0 and out_buf_idx = 0.
